// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control unit: FSM states, instruction fields
// and the datapath select codes driven by the controller.
package mips_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_F_WAIT, S_F_LATCH, S_DECODE,
    S_MEM_ADDR, S_MEM_RD, S_M_WAIT, S_MEM_LATCH, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
    S_BRANCH, S_JUMP, S_JR, S_EXC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam logic [1:0] WR_RD = 2'b00;
  localparam logic [1:0] WR_RT = 2'b01;
  localparam logic [1:0] WR_RA = 2'b10;
  localparam logic [1:0] WR_SP = 2'b11;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_SP     = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_FUNCT = 3'b011;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam int unsigned SP_INIT = 227;

endpackage

// File: rtl/mips_mc_control.sv
// Moore multicycle control FSM for the MIPS datapath, with parameterised memory wait
// states and invalid-instruction / arithmetic-overflow exception handling.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_write_not,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       aluout_write,
  output logic       epc_write,
  output logic       reg_write,
  output logic [1:0] write_reg,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [4:0] state_dbg
);

  // state       | meaning
  // RESET       | hold $29 <= SP_INIT while reset is high
  // FETCH..LATCH| PC+4, memory wait, load IR
  // DECODE      | branch target into ALUOut, dispatch on opcode/funct
  // MEM_*/R_*/I_*/BRANCH/JUMP/JR | execute, memory and write-back; EXC saves EPC

  localparam bit         HAS_WAIT  = (MEM_WAIT != 0);
  localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);

  state_t     state, state_nxt;
  logic [2:0] wait_cnt, wait_cnt_nxt;

  // zero only gates the PC enable inside the datapath
  logic unused_zero;
  assign unused_zero = zero;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RESET;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = S_FETCH;
    wait_cnt_nxt  = wait_cnt;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_write_not  = 1'b0;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    aluout_write  = 1'b0;
    epc_write     = 1'b0;
    reg_write     = 1'b0;
    write_reg     = WR_RD;
    mem_to_reg    = M2R_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;

    case (state)
      S_RESET: begin
        reg_write  = 1'b1;
        write_reg  = WR_SP;
        mem_to_reg = M2R_SP;
      end
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
        if (HAS_WAIT) begin
          state_nxt    = S_F_WAIT;
          wait_cnt_nxt = WAIT_LOAD;
        end else begin
          state_nxt = S_F_LATCH;
        end
      end
      S_F_WAIT: begin
        if (wait_cnt == 3'd0) begin
          state_nxt = S_F_LATCH;
        end else begin
          state_nxt    = S_F_WAIT;
          wait_cnt_nxt = wait_cnt - 3'd1;
        end
      end
      S_F_LATCH: begin
        ir_write  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b    = SRCB_IMM_SH2;
        aluout_write = 1'b1;
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND: state_nxt = S_R_EXEC;
              FN_JR:                  state_nxt = S_JR;
              default:                state_nxt = S_EXC;
            endcase
          end
          OP_LW, OP_SW:   state_nxt = S_MEM_ADDR;
          OP_ADDI:        state_nxt = S_I_EXEC;
          OP_BEQ, OP_BNE: state_nxt = S_BRANCH;
          OP_J, OP_JAL:   state_nxt = S_JUMP;
          default:        state_nxt = S_EXC;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
        state_nxt    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord = 1'b1;
        if (HAS_WAIT) begin
          state_nxt    = S_M_WAIT;
          wait_cnt_nxt = WAIT_LOAD;
        end else begin
          state_nxt = S_MEM_LATCH;
        end
      end
      S_M_WAIT: begin
        iord = 1'b1;
        if (wait_cnt == 3'd0) begin
          state_nxt = S_MEM_LATCH;
        end else begin
          state_nxt    = S_M_WAIT;
          wait_cnt_nxt = wait_cnt - 3'd1;
        end
      end
      S_MEM_LATCH: begin
        mdr_write = 1'b1;
        state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        write_reg  = WR_RT;
        mem_to_reg = M2R_MDR;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a    = 1'b1;
        alu_op       = ALU_FUNCT;
        aluout_write = 1'b1;
        // and cannot overflow, so its flag is ignored
        state_nxt    = (overflow && (funct == FN_ADD || funct == FN_SUB)) ? S_EXC : S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        aluout_write = 1'b1;
        state_nxt    = overflow ? S_EXC : S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        write_reg = WR_RT;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_source     = PCS_ALUOUT;
        pc_write_cond = (opcode == OP_BEQ);
        pc_write_not  = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_source = PCS_JUMP;
        pc_write  = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          write_reg  = WR_RA;
          mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        alu_src_a = 1'b1;
        pc_write  = 1'b1;
      end
      S_EXC: begin
        epc_write = 1'b1;
        pc_source = PCS_EXC;
        pc_write  = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

endmodule
